// File: rtl/spinv_pkg.sv
// Shared types and formation geometry for the space-invaders march controller.
package spinv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        MOVE,
        LANDED,
        CLEAR
    } state_t;

    localparam int NUM_ALIENS = 15;
    localparam int NUM_COLS   = 6;
    localparam int COL_BASE   = 30;
    localparam int COL_PITCH  = 100;

    // Rows 0 and 2 fill columns 0-4; the middle row is shifted one column right.
    function automatic logic [2:0] alien_col(input int idx);
        if (idx < 5)
            return 3'(idx);
        else if (idx < 10)
            return 3'(idx - 4);
        else
            return 3'(idx - 10);
    endfunction

endpackage

// File: rtl/spinv_col_scan.sv
// Combinational scan of the alive mask: outermost occupied columns and head count.
module spinv_col_scan
    import spinv_pkg::*;
(
    input  logic [NUM_ALIENS-1:0] alive,
    output logic [2:0]            col_l,
    output logic [2:0]            col_r,
    output logic                  any_alive,
    output logic [3:0]            alive_cnt
);

    logic [NUM_COLS-1:0] occ;

    // NOTE: every output gets a default before the loops so no latch is inferred.
    always_comb begin
        occ       = '0;
        col_l     = '0;
        col_r     = '0;
        alive_cnt = '0;
        for (int i = 0; i < NUM_ALIENS; i++) begin
            if (alive[i])
                occ[alien_col(i)] = 1'b1;
            alive_cnt = alive_cnt + 4'(alive[i]);
        end
        for (int c = NUM_COLS - 1; c >= 0; c--) begin
            if (occ[c])
                col_l = 3'(c);
        end
        for (int c = 0; c < NUM_COLS; c++) begin
            if (occ[c])
                col_r = 3'(c);
        end
    end

    assign any_alive = |alive;

endmodule

// File: rtl/spinv_march_ctrl.sv
// Formation march controller: step pacing, sideways march, wall drop/reverse, land/clear flags.
// Optional feature: define SPINV_SPEEDUP_EN to shorten the step period as aliens die.
module spinv_march_ctrl
    import spinv_pkg::*;
#(
    parameter int STEP_X      = 10,
    parameter int STEP_Y      = 20,
    parameter int BASE_PERIOD = 2_000_000,
    parameter int MIN_PERIOD  = 500_000,
    parameter int PER_ALIEN   = 100_000,
    parameter int LEFT_LIM    = 10,
    parameter int RIGHT_LIM   = 630,
    parameter int HALF_W      = 10,
    parameter int LAND_Y      = 240
) (
    input  logic                     Clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     freeze,
    input  logic [NUM_ALIENS-1:0]    alive,
    output logic signed [10:0]       x_off,
    output logic [9:0]               y_off,
    output logic                     dir,
    output logic                     step,
    output logic                     landed,
    output logic                     cleared,
    output logic                     busy
);

    state_t             state, state_nxt;
    logic [31:0]        cnt, cnt_nxt;
    logic [31:0]        period;
    logic signed [10:0] x_nxt;
    logic [9:0]         y_nxt;
    logic               dir_nxt, step_nxt, landed_nxt, cleared_nxt;

    logic [2:0]         col_l, col_r;
    logic               any_alive;
    logic [3:0]         alive_cnt;

    spinv_col_scan u_col_scan (
        .alive     (alive),
        .col_l     (col_l),
        .col_r     (col_r),
        .any_alive (any_alive),
        .alive_cnt (alive_cnt)
    );

`ifdef SPINV_SPEEDUP_EN
    assign period = 32'(MIN_PERIOD) + 32'(alive_cnt) * 32'(PER_ALIEN);
`else
    logic unused_alive_cnt;
    assign unused_alive_cnt = ^alive_cnt;
    assign period = 32'(BASE_PERIOD);
`endif

    // Candidate edges in 12-bit signed so a negative offset never wraps the compare.
    logic signed [11:0] x_ext, edge_r, edge_l;
    logic [10:0]        y_drop;
    logic               wall_hit;

    assign x_ext    = 12'(x_off);
    assign edge_r   = 12'(COL_BASE + COL_PITCH * int'(col_r) + STEP_X + HALF_W) + x_ext;
    assign edge_l   = 12'(COL_BASE + COL_PITCH * int'(col_l) - STEP_X - HALF_W) + x_ext;
    assign wall_hit = dir ? (edge_l < 12'(LEFT_LIM)) : (edge_r > 12'(RIGHT_LIM));
    assign y_drop   = 11'(y_off) + 11'(STEP_Y);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        x_nxt       = x_off;
        y_nxt       = y_off;
        dir_nxt     = dir;
        step_nxt    = 1'b0;
        landed_nxt  = landed;
        cleared_nxt = cleared;
        case (state)
            IDLE, LANDED, CLEAR: begin
                if (start) begin
                    x_nxt       = '0;
                    y_nxt       = '0;
                    dir_nxt     = 1'b0;
                    cnt_nxt     = '0;
                    landed_nxt  = 1'b0;
                    cleared_nxt = 1'b0;
                    state_nxt   = WAIT;
                end
            end
            WAIT: begin
                if (!any_alive) begin
                    cleared_nxt = 1'b1;
                    state_nxt   = CLEAR;
                end else if (freeze) begin
                    cnt_nxt = cnt;
                end else if (cnt >= period - 32'd1) begin
                    state_nxt = MOVE;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            MOVE: begin
                step_nxt  = 1'b1;
                cnt_nxt   = '0;
                state_nxt = WAIT;
                if (wall_hit) begin
                    y_nxt   = y_drop[9:0];
                    dir_nxt = ~dir;
                    if (y_drop >= 11'(LAND_Y)) begin
                        landed_nxt = 1'b1;
                        state_nxt  = LANDED;
                    end
                end else if (dir) begin
                    x_nxt = x_off - 11'(STEP_X);
                end else begin
                    x_nxt = x_off + 11'(STEP_X);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            x_off   <= '0;
            y_off   <= '0;
            dir     <= 1'b0;
            step    <= 1'b0;
            landed  <= 1'b0;
            cleared <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            x_off   <= x_nxt;
            y_off   <= y_nxt;
            dir     <= dir_nxt;
            step    <= step_nxt;
            landed  <= landed_nxt;
            cleared <= cleared_nxt;
        end
    end

    assign busy = (state == WAIT) || (state == MOVE);

endmodule
